cdf_builder: RTL and testbench

Upstream neighbour of the output (equalization) stage in the histogram-equalization pipeline. On `start` it streams the 256-bin histogram out of its SRAM, forms the running cumulative distribution, writes the CDF into M2 in the same packed layout, and computes `CdfMin` and `divisor` (total − CdfMin). The output stage consumes all three. `done` pulses once the last CDF word is committed.

---
 rtl/hist_eq_pkg.sv | 22 ++
 rtl/cdf_prefix4.sv | 48 ++++
 rtl/cdf_builder.sv | 156 +++++++++++++++
 tb/tb_cdf_builder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_eq_pkg.sv
// Shared definitions for the histogram-equalization pipeline: table geometry,
// lane packing constants and the CDF builder state encoding.
package hist_eq_pkg;

   localparam int LANES    = 4;
   localparam int LANE_W   = 32;
   localparam int COUNT_W  = 20;
   localparam int WORD_W   = 128;
   localparam int ADDR_W   = 16;
   localparam int NUM_BINS = 256;

   // Largest representable bin count; sums above this saturate.
   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/cdf_prefix4.sv
// Combinational 4-lane saturating prefix sum for one packed histogram word.
// Also reports the first (lowest-lane) nonzero cumulative value in the word.
module cdf_prefix4
   import hist_eq_pkg::*;
(
   input  logic [COUNT_W-1:0] accIn,
   input  logic [WORD_W-1:0]  word,
   output logic [WORD_W-1:0]  prefix,
   output logic [COUNT_W-1:0] accOut,
   output logic               ovf,
   output logic               nzValid,
   output logic [COUNT_W-1:0] nzValue
);

   logic [COUNT_W-1:0] runSum;
   logic [COUNT_W:0]   wideSum;

   // Upper lane bits carry no count information and are intentionally dropped.
   logic unusedHighBits;
   assign unusedHighBits = ^{word[127:116], word[95:84], word[63:52], word[31:20]};

   // Ripple the running sum through the lanes, clamping at COUNT_MAX; once
   // clamped the sum stays clamped because lane counts are non-negative.
   always_comb begin
      prefix  = '0;
      ovf     = 1'b0;
      nzValid = 1'b0;
      nzValue = '0;
      wideSum = '0;
      runSum  = accIn;
      for (int i = 0; i < LANES; i++) begin
         wideSum = {1'b0, runSum} + {1'b0, word[i*LANE_W +: COUNT_W]};
         if (wideSum > {1'b0, COUNT_MAX}) begin
            runSum = COUNT_MAX;
            ovf    = 1'b1;
         end else begin
            runSum = wideSum[COUNT_W-1:0];
         end
         prefix[i*LANE_W +: LANE_W] = {{(LANE_W-COUNT_W){1'b0}}, runSum};
         if (!nzValid && (runSum != '0)) begin
            nzValid = 1'b1;
            nzValue = runSum;
         end
      end
      accOut = runSum;
   end

endmodule

// File: rtl/cdf_builder.sv
// CDF builder: streams the packed histogram from M1, writes the running
// cumulative distribution to M2 and derives CdfMin and the equalization divisor.
//
// Handshake: there is no backpressure anywhere. `start` is a level that is
// only sampled while IDLE; M1 returns data exactly one cycle after the address;
// every cycle with WriteEnable=1 is a committed M2 write; `done` is a single
// cycle pulse, coherent with CdfMin/divisor/overflow.
module cdf_builder
   import hist_eq_pkg::*;
#(
   parameter logic [ADDR_W-1:0] HIST_BASE = 16'd0,
   parameter logic [ADDR_W-1:0] CDF_BASE  = 16'd0,
   parameter int                NUM_WORDS = 64
)
(
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   output logic [ADDR_W-1:0]  M1_ReadAddress,
   input  logic [WORD_W-1:0]  M1_ReadBus,
   output logic               WriteEnable,
   output logic [ADDR_W-1:0]  CDF_MEMAddress,
   output logic [WORD_W-1:0]  CDF_MEMBus,
   output logic [COUNT_W-1:0] CdfMin,
   output logic [COUNT_W-1:0] divisor,
   output logic               overflow,
   output logic               busy,
   output logic               done,
   output state_t             dbgState
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

   state_t             state;
   state_t             stateNext;
   logic [ADDR_W-1:0]  readCnt;
   logic               lastRead;
   logic               startRun;
   logic               enterDone;

   logic               dataValid;
   logic [ADDR_W-1:0]  dataIdx;

   logic [COUNT_W-1:0] acc;
   logic               found;

   logic [WORD_W-1:0]  prefix;
   logic [COUNT_W-1:0] accNext;
   logic               wordOvf;
   logic               nzValid;
   logic [COUNT_W-1:0] nzValue;

   assign lastRead  = (readCnt == LAST_IDX);
   assign startRun  = (state == IDLE) && start;
   assign enterDone = (state == DRAIN) && (stateNext == DONE);

   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign dbgState = state;

   cdf_prefix4 u_prefix (
      .accIn   (acc),
      .word    (M1_ReadBus),
      .prefix  (prefix),
      .accOut  (accNext),
      .ovf     (wordOvf),
      .nzValid (nzValid),
      .nzValue (nzValue)
   );

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= stateNext;
   end

   // Next-state logic; DRAIN ends when the final write is on the bus and
   // nothing is left in the data stage behind it.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start) stateNext = READ;
         READ:    if (lastRead) stateNext = DRAIN;
         DRAIN:   if (!dataValid && WriteEnable) stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Read address generator: one histogram address per READ cycle, held when idle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         M1_ReadAddress <= '0;
         readCnt        <= '0;
      end else if (startRun) begin
         M1_ReadAddress <= HIST_BASE;
         readCnt        <= '0;
      end else if ((state == READ) && !lastRead) begin
         M1_ReadAddress <= M1_ReadAddress + 1'b1;
         readCnt        <= readCnt + 1'b1;
      end
   end

   // Tags the cycle in which M1 data for word dataIdx is on the bus.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dataValid <= 1'b0;
         dataIdx   <= '0;
      end else begin
         dataValid <= (state == READ);
         dataIdx   <= readCnt;
      end
   end

   // Write stage: register the prefix word and its M2 address.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         WriteEnable    <= 1'b0;
         CDF_MEMAddress <= '0;
         CDF_MEMBus     <= '0;
      end else begin
         WriteEnable <= dataValid;
         if (dataValid) begin
            CDF_MEMAddress <= CDF_BASE + dataIdx;
            CDF_MEMBus     <= prefix;
         end
      end
   end

   // Accumulator and run results; divisor is formed on the edge entering DONE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc      <= '0;
         found    <= 1'b0;
         CdfMin   <= '0;
         divisor  <= '0;
         overflow <= 1'b0;
      end else if (startRun) begin
         acc      <= '0;
         found    <= 1'b0;
         CdfMin   <= '0;
         divisor  <= '0;
         overflow <= 1'b0;
      end else if (dataValid) begin
         acc <= accNext;
         if (wordOvf) overflow <= 1'b1;
         if (!found && nzValid) begin
            CdfMin <= nzValue;
            found  <= 1'b1;
         end
      end else if (enterDone) begin
         divisor <= acc - CdfMin;
      end
   end

endmodule

// File: tb/tb_cdf_builder.sv
// Directed bench for cdf_builder: uniform, single-bin, empty and saturating
// histograms, mid-run reset, held start and non-zero table bases.
module tb_cdf_builder;
   import hist_eq_pkg::*;

   localparam int T_UNIFORM = 0;
   localparam int T_SINGLE  = 1;
   localparam int T_EMPTY   = 2;
   localparam int T_SAT     = 3;

   // ---------------- clock / reset ----------------
   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   logic start   = 1'b0;
   logic sel     = 1'b0;
   always #5 clock = ~clock;

   // ---------------- DUT A (zero bases) ----------------
   logic          startA;
   logic [15:0]   addrA;
   logic [127:0]  busA = '0;
   logic          weA;
   logic [15:0]   cdfAddrA;
   logic [127:0]  cdfBusA;
   logic [19:0]   cdfMinA, divA;
   logic          ovfA, busyA, doneA;
   state_t        stateA;

   // ---------------- DUT B (shifted bases) ----------------
   logic          startB;
   logic [15:0]   addrB;
   logic [127:0]  busB = '0;
   logic          weB;
   logic [15:0]   cdfAddrB;
   logic [127:0]  cdfBusB;
   logic [19:0]   cdfMinB, divB;
   logic          ovfB, busyB, doneB;
   state_t        stateB;

   assign startA = start & ~sel;
   assign startB = start & sel;

   cdf_builder dut (
      .clock(clock), .reset_n(reset_n), .start(startA),
      .M1_ReadAddress(addrA), .M1_ReadBus(busA),
      .WriteEnable(weA), .CDF_MEMAddress(cdfAddrA), .CDF_MEMBus(cdfBusA),
      .CdfMin(cdfMinA), .divisor(divA), .overflow(ovfA),
      .busy(busyA), .done(doneA), .dbgState(stateA)
   );

   cdf_builder #(.HIST_BASE(16'h100), .CDF_BASE(16'h40), .NUM_WORDS(64)) dutB (
      .clock(clock), .reset_n(reset_n), .start(startB),
      .M1_ReadAddress(addrB), .M1_ReadBus(busB),
      .WriteEnable(weB), .CDF_MEMAddress(cdfAddrB), .CDF_MEMBus(cdfBusB),
      .CdfMin(cdfMinB), .divisor(divB), .overflow(ovfB),
      .busy(busyB), .done(doneB), .dbgState(stateB)
   );

   // Selected view of whichever DUT is under test.
   logic          we, busy, done, ovf;
   logic [15:0]   rdAddr, cdfAddr;
   logic [127:0]  cdfBus;
   logic [19:0]   cdfMin, divv;
   state_t        stDbg;
   assign we      = sel ? weB      : weA;
   assign busy    = sel ? busyB    : busyA;
   assign done    = sel ? doneB    : doneA;
   assign ovf     = sel ? ovfB     : ovfA;
   assign rdAddr  = sel ? addrB    : addrA;
   assign cdfAddr = sel ? cdfAddrB : cdfAddrA;
   assign cdfBus  = sel ? cdfBusB  : cdfBusA;
   assign cdfMin  = sel ? cdfMinB  : cdfMinA;
   assign divv    = sel ? divB     : divA;
   assign stDbg   = sel ? stateB   : stateA;

   // ---------------- histogram memory model ----------------
   logic [19:0] hist [256];
   int curTest = T_UNIFORM;

   // Junk in lane bits [31:20] must be ignored by the DUT.
   function automatic logic [127:0] packWord(input int k);
      logic [127:0] w;
      w = '0;
      for (int i = 0; i < 4; i++)
         w[32*i +: 32] = {12'hA5C ^ 12'(4*k + i), hist[4*k + i]};
      return w;
   endfunction

   always @(posedge clock) begin
      busA <= packWord(int'(addrA[5:0]));
      busB <= packWord(int'(6'(addrB - 16'h100)));
   end

   task automatic loadHist(input int t);
      for (int b = 0; b < 256; b++) begin
         case (t)
            T_UNIFORM: hist[b] = 20'd4;
            T_SINGLE:  hist[b] = (b == 200) ? 20'd1000 : 20'd0;
            T_SAT:     hist[b] = (b == 0) ? 20'hFFFF0 : ((b == 1) ? 20'h00020 : 20'd0);
            default:   hist[b] = 20'd0;
         endcase
      end
   endtask

   // Hand-derived CDF word k for each directed histogram.
   function automatic logic [127:0] expWord(input int t, input int k);
      logic [127:0] w;
      w = '0;
      for (int i = 0; i < 4; i++) begin
         case (t)
            T_UNIFORM: w[32*i +: 32] = 32'(16*k + 4*(i+1));
            T_SINGLE:  w[32*i +: 32] = (k >= 50) ? 32'd1000 : 32'd0;
            T_SAT:     w[32*i +: 32] = (k == 0 && i == 0) ? 32'h000FFFF0 : 32'h000FFFFF;
            default:   w[32*i +: 32] = 32'd0;
         endcase
      end
      return w;
   endfunction

   // ---------------- scoreboard ----------------
   logic [127:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Entered just after a falling edge. Runs to the falling edge of cycle 68,
   // or aborts with a reset at cycle abortAt.
   task automatic runCheck(input bit holdStart, input int abortAt,
                           input logic [15:0] hBase, input logic [15:0] cBase,
                           input logic [19:0] expMin, input logic [19:0] expDiv,
                           input logic expOvf);
      int wrCount   = 0;
      int doneCycle = -1;
      bit sawDone   = 1'b0;
      exp_q.delete();
      for (int k = 0; k < 64; k++) exp_q.push_back(expWord(curTest, k));
      start = 1'b1;
      @(posedge clock);
      #1;
      if (!holdStart) start = 1'b0;
      for (int c = 1; c <= 68; c++) begin
         @(negedge clock);
         if (c == abortAt) begin
            reset_n = 1'b0;
            #1;
            check("abort_we",   128'(we),     128'(0));
            check("abort_busy", 128'(busy),   128'(0));
            check("abort_min",  128'(cdfMin), 128'(0));
            check("abort_div",  128'(divv),   128'(0));
            check("abort_ovf",  128'(ovf),    128'(0));
            exp_q.delete();
            repeat (3) @(negedge clock);
            reset_n = 1'b1;
            for (int j = 0; j < 70; j++) begin
               @(negedge clock);
               if (done || we) sawDone = 1'b1;
            end
            check("abort_no_done_or_write", 128'(sawDone), 128'(0));
            return;
         end
         if (c <= 64) check("rd_addr", 128'(rdAddr), 128'(hBase + 16'(c - 1)));
         if (c == 66) check("rd_addr_hold", 128'(rdAddr), 128'(hBase + 16'd63));
         if (we) begin
            check("wr_cycle", 128'(c), 128'(3 + wrCount));
            check("wr_addr", 128'(cdfAddr), 128'(cBase + 16'(wrCount)));
            if (exp_q.size() == 0) check("wr_extra", 128'(1), 128'(0));
            else                   check("wr_data", cdfBus, exp_q.pop_front());
            wrCount++;
         end
         if (done) begin
            doneCycle = c;
            check("cdf_min",  128'(cdfMin), 128'(expMin));
            check("divisor",  128'(divv),   128'(expDiv));
            check("overflow", 128'(ovf),    128'(expOvf));
         end
         if (c == 67) check("busy_last", 128'(busy), 128'(1));
         if (c == 68) begin
            check("busy_idle",  128'(busy),   128'(0));
            check("state_idle", 128'(stDbg),  128'(IDLE));
            check("min_hold",   128'(cdfMin), 128'(expMin));
            check("div_hold",   128'(divv),   128'(expDiv));
         end
      end
      check("done_cycle", 128'(doneCycle), 128'(67));
      check("wr_count",   128'(wrCount),   128'(64));
   endtask

   // ---------------- sequence ----------------
   initial begin
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_we",    128'(weA),     128'(0));
      check("rst_busy",  128'(busyA),   128'(0));
      check("rst_done",  128'(doneA),   128'(0));
      check("rst_min",   128'(cdfMinA), 128'(0));
      check("rst_div",   128'(divA),    128'(0));
      check("rst_ovf",   128'(ovfA),    128'(0));
      check("rst_addr",  128'(addrA),   128'(0));
      check("rst_state", 128'(stateA),  128'(IDLE));
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      curTest = T_UNIFORM; loadHist(curTest);
      runCheck(1'b0, 0, 16'h0, 16'h0, 20'd4, 20'd1020, 1'b0);
      repeat (2) @(negedge clock);

      curTest = T_SINGLE; loadHist(curTest);
      runCheck(1'b0, 0, 16'h0, 16'h0, 20'd1000, 20'd0, 1'b0);
      repeat (2) @(negedge clock);

      curTest = T_EMPTY; loadHist(curTest);
      runCheck(1'b0, 0, 16'h0, 16'h0, 20'd0, 20'd0, 1'b0);
      repeat (2) @(negedge clock);

      curTest = T_SAT; loadHist(curTest);
      runCheck(1'b0, 0, 16'h0, 16'h0, 20'hFFFF0, 20'h0000F, 1'b1);
      repeat (2) @(negedge clock);

      curTest = T_UNIFORM; loadHist(curTest);
      runCheck(1'b0, 30, 16'h0, 16'h0, 20'd4, 20'd1020, 1'b0);
      repeat (2) @(negedge clock);
      runCheck(1'b0, 0, 16'h0, 16'h0, 20'd4, 20'd1020, 1'b0);
      repeat (2) @(negedge clock);

      // start held through the first run; the second is accepted at edge 68.
      runCheck(1'b1, 0, 16'h0, 16'h0, 20'd4, 20'd1020, 1'b0);
      runCheck(1'b0, 0, 16'h0, 16'h0, 20'd4, 20'd1020, 1'b0);
      repeat (2) @(negedge clock);

      sel = 1'b1;
      runCheck(1'b0, 0, 16'h100, 16'h40, 20'd4, 20'd1020, 1'b0);
      sel = 1'b0;
      repeat (2) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
